dft_mac_sequencer: RTL and testbench

- Sequences the direct-DFT multiply-accumulate datapath: cache read/twiddle index generation, accumulator clear/enable alignment, and result write-back handshake.
- For every bin k in 0..N-1: issues n = 0..N-1, waits for the multiply/round pipeline to drain, then presents the accumulated bin to the RAM write port and stalls until it is accepted.
- Sits between the top-level mode FSM (start/done) and the counters/accumulator it replaces.

---
 rtl/fft_pkg.sv | 18 +
 rtl/dft_valid_delay.sv | 32 +++
 rtl/dft_mac_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dft_mac_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and default constants for the direct-DFT sequencing logic.
package fft_pkg;

  localparam int FFT_ADDR_W   = 12;
  localparam int FFT_PIPE_LAT = 2;

  // Wide enough for any legal pipeline latency (1..7).
  localparam int FFT_DRAIN_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } dft_seq_state_t;

endpackage

// File: rtl/dft_valid_delay.sv
// Single-bit valid delay line, PIPE_LAT stages deep, with synchronous clear.
// Aligns the accumulator enable with data leaving the multiply/round pipeline.
module dft_valid_delay
  import fft_pkg::*;
#(
  parameter int PIPE_LAT = FFT_PIPE_LAT
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_valid,
  output logic o_valid
);

  logic [PIPE_LAT-1:0] r_shift;

  if (PIPE_LAT == 1) begin : g_one
    // Single stage: plain register.
    always_ff @(posedge clk) begin
      if (i_clear) r_shift <= '0;
      else         r_shift <= i_valid;
    end
  end else begin : g_multi
    // Shift toward the MSB; the MSB is the delayed output.
    always_ff @(posedge clk) begin
      if (i_clear) r_shift <= '0;
      else         r_shift <= {r_shift[PIPE_LAT-2:0], i_valid};
    end
  end

  assign o_valid = r_shift[PIPE_LAT-1];

endmodule

// File: rtl/dft_mac_sequencer.sv
// Direct-DFT multiply-accumulate sequencer: walks bins k and samples n,
// aligns accumulator clear/enable with the pipeline and hands each bin to
// the write-back port.
// Optional macro DFT_MAC_SEQUENCER_PERF_EN adds o_stall_cycles, the number of
// cycles a finished bin waited for the write-back sink.
//
// state  | meaning
// IDLE   | waiting for start; rejects N == 0 with an error pulse
// RUN    | issuing n = 0..N-1 for the current bin
// DRAIN  | waiting PIPE_LAT cycles for the last product to land
// RESULT | presenting bin k, held until the sink accepts it
// DONE   | one-cycle completion pulse
module dft_mac_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_W   = FFT_ADDR_W,
  parameter int PIPE_LAT = FFT_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_samp_number,
  input  logic              i_res_ready,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_n_index,
  output logic [ADDR_W-1:0] o_k_index,
  output logic              o_issue,
  output logic              o_acc_clear,
  output logic              o_mac_ce,
  output logic              o_res_valid,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic              o_done,
  output logic              o_err
`ifdef DFT_MAC_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  localparam logic [FFT_DRAIN_W-1:0] DRAIN_LOAD = FFT_DRAIN_W'(PIPE_LAT - 1);

  dft_seq_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]      r_n;
  logic [ADDR_W-1:0]      r_k;
  logic [ADDR_W-1:0]      r_n_total;
  logic [FFT_DRAIN_W-1:0] r_drain;
  logic                   r_err;

  logic w_start_ok;
  logic w_start_bad;
  logic w_issue;
  logic w_clear;
  logic w_valid;
  logic w_accept;
  logic w_done;
  logic w_last_n;
  logic w_last_k;
  logic w_mac_ce;

  // Terminal compares against N-1 so n and k never wrap.
  assign w_last_n = (r_n == (r_n_total - ADDR_W'(1)));
  assign w_last_k = (r_k == (r_n_total - ADDR_W'(1)));

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_issue     = 1'b0;
    w_clear     = 1'b0;
    w_valid     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_samp_number != '0) begin
            w_start_ok  = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        w_issue = 1'b1;
        w_clear = (r_n == '0);
        if (w_last_n) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain == '0) w_state_nxt = RESULT;
      end
      RESULT: begin
        w_valid = 1'b1;
        if (i_res_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = w_last_k ? DONE : RUN;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Index counters, captured N, drain down-counter and registered error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n       <= '0;
      r_k       <= '0;
      r_n_total <= '0;
      r_drain   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_start_bad;
      if (w_start_ok) begin
        r_n_total <= i_samp_number;
        r_n       <= '0;
        r_k       <= '0;
      end
      if (r_state == RUN) begin
        if (w_last_n) begin
          r_n     <= '0;
          r_drain <= DRAIN_LOAD;
        end else begin
          r_n <= r_n + ADDR_W'(1);
        end
      end
      if ((r_state == DRAIN) && (r_drain != '0)) r_drain <= r_drain - FFT_DRAIN_W'(1);
      if (w_accept && !w_last_k) r_k <= r_k + ADDR_W'(1);
    end
  end

  // The delay line only forgets in-flight issues on reset, never on state changes.
  dft_valid_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_delay (
    .clk     (clk),
    .i_clear (rst),
    .i_valid (w_issue),
    .o_valid (w_mac_ce)
  );

`ifdef DFT_MAC_SEQUENCER_PERF_EN
  logic [31:0] r_stall;

  // Saturating count of cycles the finished bin waited on the sink.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == RESULT) && !i_res_ready && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall;
`endif

  // Indices are gated so idle outputs read as zero.
  assign o_busy      = (r_state != IDLE);
  assign o_issue     = w_issue;
  assign o_n_index   = w_issue ? r_n : '0;
  assign o_k_index   = w_issue ? r_k : '0;
  assign o_acc_clear = w_clear;
  assign o_mac_ce    = w_mac_ce;
  assign o_res_valid = w_valid;
  assign o_res_addr  = w_valid ? r_k : '0;
  assign o_done      = w_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_dft_mac_sequencer.sv
// Self-checking bench for dft_mac_sequencer: directed scenarios plus randomized
// runs, compared cycle by cycle against a timeline model built from the bin
// timing rules (issue window, drain, handshake wait, done).
module tb_dft_mac_sequencer;

  localparam int AW   = 12;
  localparam int PL   = 2;
  localparam int MAXC = 1024;

  typedef logic [42:0] vec_t;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_samp_number;
  logic          i_res_ready;
  logic          o_busy;
  logic [AW-1:0] o_n_index;
  logic [AW-1:0] o_k_index;
  logic          o_issue;
  logic          o_acc_clear;
  logic          o_mac_ce;
  logic          o_res_valid;
  logic [AW-1:0] o_res_addr;
  logic          o_done;
  logic          o_err;
`ifdef DFT_MAC_SEQUENCER_PERF_EN
  logic [31:0]   o_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  bit          ready_pat [MAXC];
  vec_t        exp_v     [MAXC];
  int unsigned exp_stalls;
  int          exp_done_c;

  dft_mac_sequencer #(
    .ADDR_W   (AW),
    .PIPE_LAT (PL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_samp_number (i_samp_number),
    .i_res_ready   (i_res_ready),
    .o_busy        (o_busy),
    .o_n_index     (o_n_index),
    .o_k_index     (o_k_index),
    .o_issue       (o_issue),
    .o_acc_clear   (o_acc_clear),
    .o_mac_ce      (o_mac_ce),
    .o_res_valid   (o_res_valid),
    .o_res_addr    (o_res_addr),
    .o_done        (o_done),
    .o_err         (o_err)
`ifdef DFT_MAC_SEQUENCER_PERF_EN
    ,
    .o_stall_cycles(o_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit busy, bit issue, int n, int k, bit clr, bit ce,
                              bit val, int addr, bit done, bit err);
    return {busy, issue, AW'(n), AW'(k), clr, ce, val, AW'(addr), done, err};
  endfunction

  function automatic vec_t observe();
    return {o_busy, o_issue, o_n_index, o_k_index, o_acc_clear, o_mac_ce,
            o_res_valid, o_res_addr, o_done, o_err};
  endfunction

  // Timeline model: start accepted in cycle 0; each bin issues N samples, waits
  // PL cycles, then shows its result until the sink is ready.
  task automatic build_model(input int ns, input int abort_c, output int end_c);
    int t;
    int c;
    for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
    exp_stalls = 0;
    exp_done_c = -1;
    if (ns == 0) begin
      exp_v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      end_c = 4;
    end else begin
      t = 1;
      for (int k = 0; k < ns; k++) begin
        for (int i = t; i < t + ns + PL; i++) exp_v[i] |= mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < ns; n++) begin
          exp_v[t + n]      |= mk(1, 1, n, k, (n == 0), 0, 0, 0, 0, 0);
          exp_v[t + n + PL] |= mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        c = t + ns + PL;
        while (1) begin
          exp_v[c] |= mk(1, 0, 0, 0, 0, 0, 1, k, 0, 0);
          if (ready_pat[c]) break;
          exp_stalls++;
          c++;
        end
        t = c + 1;
      end
      exp_v[t] |= mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      exp_done_c = t;
      end_c = t + 3;
    end
    if (abort_c >= 0) begin
      for (int i = abort_c + 1; i < MAXC; i++) exp_v[i] = '0;
      exp_done_c = -1;
      end_c = abort_c + 4;
    end
  endtask

  task automatic run_case(input string tag, input int ns, input int busy_start_c,
                          input int abort_c, output int done_c, output int issues);
    int end_c;
    vec_t obs;
    build_model(ns, abort_c, end_c);
    done_c = -1;
    issues = 0;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      obs = observe();
      checks++;
      assert (obs === exp_v[c])
      else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp_v[c]);
      end
      if (o_done) done_c = c;
      if (o_issue) issues++;
      i_start       = (c == 0) || (c == busy_start_c);
      i_samp_number = (c == 0) ? AW'(ns) : ((c == busy_start_c) ? AW'(7) : AW'($urandom));
      i_res_ready   = ready_pat[c];
      rst           = (c == abort_c);
    end
    i_start = 1'b0;
    rst     = 1'b0;
    checks++;
    assert (done_c === exp_done_c)
    else begin
      errors++;
      $error("FAIL %s_done_cycle observed=%0d expected=%0d", tag, done_c, exp_done_c);
    end
`ifdef DFT_MAC_SEQUENCER_PERF_EN
    if (abort_c < 0 && ns != 0) begin
      checks++;
      assert (o_stall_cycles === exp_stalls)
      else begin
        errors++;
        $error("FAIL %s_stalls observed=%0d expected=%0d", tag, o_stall_cycles, exp_stalls);
      end
    end
`endif
  endtask

  task automatic fill_ready_high();
    for (int i = 0; i < MAXC; i++) ready_pat[i] = 1'b1;
  endtask

  task automatic fill_ready_random();
    for (int i = 0; i < MAXC; i++) ready_pat[i] = (i > 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int dc;
    int is;
    int ns;
    rst           = 1'b1;
    i_start       = 1'b0;
    i_samp_number = '0;
    i_res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (observe() === '0)
    else begin
      errors++;
      $error("FAIL reset_outputs observed=%h expected=0", observe());
    end
`ifdef DFT_MAC_SEQUENCER_PERF_EN
    checks++;
    assert (o_stall_cycles === 32'd0)
    else begin
      errors++;
      $error("FAIL reset_stalls observed=%0d expected=0", o_stall_cycles);
    end
`endif
    rst = 1'b0;
    @(negedge clk);

    // Nominal N=4 with ready tied high.
    fill_ready_high();
    run_case("nominal", 4, -1, -1, dc, is);
    checks++;
    assert (dc === 29) else begin errors++; $error("FAIL nominal_done observed=%0d expected=29", dc); end
    checks++;
    assert (is === 16) else begin errors++; $error("FAIL nominal_issues observed=%0d expected=16", is); end

    // Backpressure: bin 0 result (cycle 5) waits 5 cycles.
    fill_ready_high();
    for (int i = 5; i < 10; i++) ready_pat[i] = 1'b0;
    run_case("backpressure", 2, -1, -1, dc, is);
    checks++;
    assert (dc === 16) else begin errors++; $error("FAIL bp_done observed=%0d expected=16", dc); end
    checks++;
    assert (exp_stalls === 5) else begin errors++; $error("FAIL bp_model_stalls observed=%0d expected=5", exp_stalls); end

    // Boundaries: N=1 and rejected N=0.
    fill_ready_high();
    run_case("n1", 1, -1, -1, dc, is);
    checks++;
    assert (dc === 5) else begin errors++; $error("FAIL n1_done observed=%0d expected=5", dc); end
    checks++;
    assert (is === 1) else begin errors++; $error("FAIL n1_issues observed=%0d expected=1", is); end
    run_case("n0", 0, -1, -1, dc, is);

    // Start while busy is ignored.
    run_case("busy_start", 4, 3, -1, dc, is);
    checks++;
    assert (dc === 29) else begin errors++; $error("FAIL busy_start_done observed=%0d expected=29", dc); end

    // Reset during DRAIN of bin 2 (cycle 19), then a fresh N=3 run.
    run_case("abort", 4, -1, 19, dc, is);
    fill_ready_random();
    run_case("after_abort", 3, -1, -1, dc, is);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      ns = $urandom_range(1, 6);
      fill_ready_random();
      run_case($sformatf("rand%0d_n%0d", r, ns), ns, (r % 2 == 0) ? 2 : -1, -1, dc, is);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
